// File: rtl/multiprecision_add_ctrl.sv
// Multi-word adder sequencer: one shared 16-bit carry-lookahead adder processes one word per clock, LSW first.
// Optional subtract support is enabled by defining MPADD_SUB_EN.

module carry_lookahead_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  cg_s;

    // Two-level lookahead: 4-bit group generate/propagate, then per-bit carries from the group carry-in.
    always_comb begin
        g_s  = a & b;
        p_s  = a ^ b;
        gg_s = 4'b0000;
        gp_s = 4'b0000;
        cg_s = 5'b00000;
        c_s  = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2]) | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            gp_s[k] = &p_s[4*k +: 4];
        end
        cg_s[0] = cin;
        cg_s[1] = gg_s[0] | (gp_s[0] & cin);
        cg_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        cg_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        cg_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0]) | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = cg_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & cg_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k]) | (p_s[4*k+1] & p_s[4*k] & cg_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1]) | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & cg_s[k]);
        end
        sum  = p_s ^ c_s;
        cout = cg_s[4];
    end
endmodule

module multiprecision_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a_in,
    input  logic [16*WORDS-1:0] b_in,
    input  logic                cin,
`ifdef MPADD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] s_out,
    output logic                cout,
    output logic                overflow
);
    localparam int W    = 16 * WORDS;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            take_s;
    logic            sub_s;
    logic [15:0]     cla_a_s;
    logic [15:0]     cla_b_s;
    logic [15:0]     cla_sum_s;
    logic            cla_cout_s;

`ifdef MPADD_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // b_q holds B' (already inverted when subtracting), so the datapath is add-only.
    assign cla_a_s = a_q[{idx_q, 4'b0000} +: 16];
    assign cla_b_s = b_q[{idx_q, 4'b0000} +: 16];

    carry_lookahead_16bits u_cla (
        .a    (cla_a_s),
        .b    (cla_b_s),
        .cin  (carry_q),
        .sum  (cla_sum_s),
        .cout (cla_cout_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        take_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    take_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[{idx_q, 4'b0000} +: 16] = cla_sum_s;
                carry_d = cla_cout_s;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_cout_s;
                    ovf_d   = (cla_a_s[15] == cla_b_s[15]) && (cla_sum_s[15] != cla_a_s[15]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    take_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take_s) begin
            a_d     = a_in;
            b_d     = sub_s ? ~b_in : b_in;
            carry_d = sub_s ? 1'b1 : cin;
            idx_d   = '0;
            s_d     = '0;
            state_d = RUN;
        end else begin
            take_s = 1'b0;
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign s_out    = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_multiprecision_add_ctrl.sv
// Randomized self-checking bench for multiprecision_add_ctrl (WORDS=4) against an exact-arithmetic reference.
module tb_multiprecision_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        cin;
    logic        sub_v;
    logic        busy;
    logic        done;
    logic [63:0] s_out;
    logic        cout;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    multiprecision_add_ctrl #(.WORDS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
`ifdef MPADD_SUB_EN
        .sub      (sub_v),
`endif
        .busy     (busy),
        .done     (done),
        .s_out    (s_out),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Exact signed/unsigned arithmetic: overflow when the true signed result leaves the 64-bit range.
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b, input logic ci,
                                      input logic sb, output logic [63:0] s, output logic co,
                                      output logic ov);
        logic [64:0]        t;
        logic signed [65:0] ex;
        logic signed [65:0] sa;
        logic signed [65:0] sbv;
        sa  = $signed({{2{a[63]}}, a});
        sbv = $signed({{2{b[63]}}, b});
        if (sb) begin
            t  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            ex = sa - sbv;
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
            co = t[64];
            ex = sa + sbv + $signed({65'd0, ci});
        end
        s  = t[63:0];
        ov = !((ex[65:63] == 3'b000) || (ex[65:63] == 3'b111));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb_req,
                         input string name);
        logic [63:0] es;
        logic        eco;
        logic        eov;
        logic        sb;
        logic        overlap;
        logic [63:0] held;
        int          lat;
        int          bcnt;
`ifdef MPADD_SUB_EN
        sb = sb_req;
`else
        sb = 1'b0;
`endif
        ref_model(a, b, ci, sb, es, eco, eov);
        @(negedge clk);
        a_in = a; b_in = b; cin = ci; sub_v = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; bcnt = 0; overlap = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            a_in = rnd64(); b_in = rnd64(); cin = 1'($urandom_range(0, 1)); sub_v = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1 after 4", name, done, lat);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL %s latency: got %0d required 4", name, lat);
        end
        checks++;
        if (bcnt !== 4 || busy !== 1'b0 || overlap) begin
            failures++;
            $display("FAIL %s busy: cycles %0d busy_at_done %b overlap %b, required 4/0/0", name, bcnt, busy, overlap);
        end
        checks++;
        if (s_out !== es) begin
            failures++;
            $display("FAIL %s s_out: got %h required %h", name, s_out, es);
        end
        checks++;
        if (cout !== eco || overflow !== eov) begin
            failures++;
            $display("FAIL %s cout/overflow: got %b/%b required %b/%b", name, cout, overflow, eco, eov);
        end
        held = es;
        a_in = rnd64(); b_in = rnd64();
        @(negedge clk);
        checks++;
        if (s_out !== held || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s hold: s_out %h done %b busy %b, required %h 0 0", name, s_out, done, busy, held);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub_v = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0000 || s_out !== 64'd0) begin
            failures++;
            $display("FAIL reset: busy %b done %b cout %b ovf %b s_out %h, required all 0", busy, done, cout, overflow, s_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1234_5678_9ABC_DEF0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0000 || s_out !== 64'd0) begin
            failures++;
            $display("FAIL mid_run_reset: busy %b done %b cout %b ovf %b s_out %h, required all 0", busy, done, cout, overflow, s_out);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(64'd1, 64'd1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_boundaries();
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, "ripple");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "signed_ovf");
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, "neg_ovf");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2, e1, e2;
        logic        c1, c2, co1, co2, ov1, ov2;
        int          n, first, second, ndone;
        a1 = rnd64(); b1 = rnd64(); c1 = 1'($urandom_range(0, 1));
        a2 = rnd64(); b2 = rnd64(); c2 = 1'($urandom_range(0, 1));
        ref_model(a1, b1, c1, 1'b0, e1, co1, ov1);
        ref_model(a2, b2, c2, 1'b0, e2, co2, ov2);
        @(negedge clk);
        a_in = a1; b_in = b1; cin = c1; sub_v = 1'b0; start = 1'b1;
        @(negedge clk);
        n = 0; first = -1; second = -1; ndone = 0;
        while (ndone < 2 && n < 30) begin
            if (done === 1'b1) begin
                checks++;
                if (ndone == 0) begin
                    if (s_out !== e1 || cout !== co1 || overflow !== ov1) begin
                        failures++;
                        $display("FAIL b2b_first: got %h/%b/%b required %h/%b/%b", s_out, cout, overflow, e1, co1, ov1);
                    end
                    first = n;
                    a_in = a2; b_in = b2; cin = c2;
                end else begin
                    if (s_out !== e2 || cout !== co2 || overflow !== ov2) begin
                        failures++;
                        $display("FAIL b2b_second: got %h/%b/%b required %h/%b/%b", s_out, cout, overflow, e2, co2, ov2);
                    end
                    second = n;
                    start = 1'b0;
                end
                ndone++;
            end else begin
                a_in = rnd64(); b_in = rnd64(); cin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (first !== 4 || second - first !== 5) begin
            failures++;
            $display("FAIL b2b_timing: first done at %0d gap %0d, required 4 and 5", first, second - first);
        end
    endtask

    task automatic test_subtract();
`ifdef MPADD_SUB_EN
        do_op(64'd5, 64'd7, 1'b0, 1'b1, "sub_neg");
        do_op(64'd7, 64'd5, 1'b0, 1'b1, "sub_pos");
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, "sub_ovf");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            do_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_boundaries();
        test_back_to_back();
        test_subtract();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multiprecision_add_ctrl.md
# multiprecision_add_ctrl

Sequencer that performs a multi-word (16×WORDS-bit) addition by time-multiplexing a single `carry_lookahead_16bits` instance, one 16-bit word per clock, least-significant word first. The carry is registered between words. It sits between a host that issues add requests with a start/done handshake and the shared 16-bit CLA datapath. It trades WORDS cycles of latency for one 16-bit adder's area.

## Interface
Parameters:
- WORDS, 4, number of 16-bit words per operand (≥2); operand width W = 16*WORDS

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- a_in  input  W  operand A; captured on the accepted start
- b_in  input  W  operand B; captured on the accepted start
- cin  input  1  carry-in to word 0; captured on the accepted start
- sub  input  1  subtract select; present only with MPADD_SUB_EN; captured on the accepted start
- busy  output  1  high while words are being processed
- done  output  1  one-cycle pulse; results are valid
- s_out  output  W  sum; held stable from done until the next accepted start
- cout  output  1  carry-out of the top word
- overflow  output  1  two's-complement overflow of the full W-bit result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE / DONE with start=1:
  - Latch a_in, b_in, cin (and sub) into internal registers.
  - idx ← 0; carry register ← effective cin; clear s_out.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - CLA inputs: a = A[16*idx +: 16], b = B'[16*idx +: 16], cin = carry register.
  - s_out[16*idx +: 16] ← CLA sum; carry register ← CLA cout; idx ← idx+1.
  - When idx == WORDS-1: also cout ← CLA cout and overflow ← (a15 == b15) && (sum15 != a15), using the top word's CLA operands. Go to DONE.
- B' is B, or ~B when subtracting. Effective cin is cin, or 1 when subtracting.
- start during RUN is ignored; no queueing.
- idx width: $clog2(WORDS); it must not wrap before the transition to DONE.
- All arithmetic is unsigned modulo 2^W; cout is bit W of A + B' + cin.

## Timing
- Reset (any time, including mid-RUN): state=IDLE, idx=0, carry=0, busy=0, done=0, s_out=0, cout=0, overflow=0. The in-flight operation is discarded.
- Edge E0 samples start=1 in IDLE → busy=1 after E0.
- Edges E1..E_WORDS process words 0..WORDS-1.
- After E_WORDS: state=DONE, done=1, busy=0, and s_out/cout/overflow are final.
- After E_WORDS+1: done=0, unless start was high in DONE, in which case the next operation begins (back-to-back, no idle cycle).
- Latency from the start edge to done = WORDS cycles; throughput is one operation per WORDS+1 cycles.
- busy and done are never high in the same cycle.
- s_out words are written progressively during RUN. s_out is only guaranteed valid when done=1 and while in IDLE afterwards.
- The CLA path is combinational from registers to registers: one word per cycle, with no combinational path from inputs to outputs.

## Configuration
- MPADD_SUB_EN defined:
  - The sub port exists.
  - When sub=1 is captured: B' = ~B and effective cin = 1, so the result is A − B; the external cin is ignored.
  - cout=1 means no borrow.
- MPADD_SUB_EN undefined:
  - No sub port.
  - B' = B and effective cin = cin; add only.

## Test plan
(WORDS=4, W=64)
- Reset mid-RUN: assert rst two cycles after start → on the same cycle all outputs are 0 and state is IDLE; a following start with A=1, B=1, cin=0 → after 4 cycles done=1, s_out=2, cout=0.
- Full carry ripple: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → s_out=0, cout=1, overflow=0; done exactly 4 cycles after the start edge; busy high for exactly 4 cycles.
- Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, cin=0 → s_out=64'h8000_0000_0000_0000, cout=0, overflow=1.
- Back-to-back with ignored start:
  - Hold start=1 continuously; change operands during RUN.
  - Required: only values present at the start edges are used.
  - Required: the second done occurs 5 cycles after the first; start pulses during RUN have no effect.
- Subtract (MPADD_SUB_EN): A=5, B=7, sub=1 → s_out=64'hFFFF_FFFF_FFFF_FFFE, cout=0. A=7, B=5, sub=1 → s_out=2, cout=1.
- Random: 1000 random A, B, cin values checked against a 65-bit reference sum. s_out must be stable from done until the next start.
